avl_bus_arbiter: RTL and testbench

Two-to-one Avalon-MM master arbiter between the CPU's instruction-fetch and data (load/store) request ports and the single Avalon slave memory (`avl_slave_mem_dbg`). Each transaction is granted to one requester, and its address, byteenable and writedata are latched. The arbiter drives `avm_read`/`avm_write` until `avm_waitrequest` drops, captures read data, and returns a one-cycle completion pulse to the granted requester. It sits directly upstream of the memory, between the CPU core and the bus.

---
 rtl/avl_arb_pkg.sv | 19 +
 rtl/avl_bus_arbiter_if.sv | 33 +++
 rtl/avl_arb_pick.sv | 33 +++
 rtl/avl_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_avl_bus_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/avl_arb_pkg.sv
// avl_arb_pkg: shared types and constants for the two-port Avalon-MM arbiter.
// Optional feature macro used by the arbiter files: ARB_ROUND_ROBIN_EN.
package avl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Instruction fetches are always full-word accesses.
    localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/avl_bus_arbiter_if.sv
// avl_bus_arbiter_if: Avalon-MM master/slave signal bundle between the arbiter
// and the memory slave. The arbiter uses the master modport.
interface avl_bus_arbiter_if;

    logic [31:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_byteenable,
        output avm_writedata,
        output avm_read,
        output avm_write,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_byteenable,
        input  avm_writedata,
        input  avm_read,
        input  avm_write,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/avl_arb_pick.sv
// avl_arb_pick: combinational winner selection between the fetch and data ports.
// Build option ARB_ROUND_ROBIN_EN: simultaneous requests go to the port that
// did not win last; otherwise data always beats fetch.
module avl_arb_pick
    import avl_arb_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  grant_t last_gnt_i,
`endif
    output logic   valid_o,
    output grant_t gnt_o
);

    // Select the winning requester for this IDLE cycle.
    always_comb begin
        valid_o = i_req_i | d_req_i;
        gnt_o   = GNT_I;
        if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            gnt_o = (last_gnt_i == GNT_D) ? GNT_I : GNT_D;
`else
            gnt_o = GNT_D;
`endif
        end else if (d_req_i) begin
            gnt_o = GNT_D;
        end else begin
            gnt_o = GNT_I;
        end
    end

endmodule

// File: rtl/avl_bus_arbiter.sv
// avl_bus_arbiter: two-to-one Avalon-MM master arbiter (instruction fetch vs
// data load/store) in front of a single Avalon slave memory.
// Build option ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests
// using a grant-history register; undefined = fixed data-over-fetch priority.
module avl_bus_arbiter
    import avl_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic        i_done,
    output logic [31:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    avl_bus_arbiter_if.master avm
);

    state_t      state_q,   state_d;
    grant_t      gnt_q,     gnt_d;
    logic [31:0] addr_q,    addr_d;
    logic [3:0]  be_q,      be_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        read_q,    read_d;
    logic        write_q,   write_d;
    logic        i_done_q,  i_done_d;
    logic        d_done_q,  d_done_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        pick_valid_s;
    grant_t      pick_gnt_s;

`ifdef ARB_ROUND_ROBIN_EN
    grant_t      hist_q, hist_d;
`endif

    avl_arb_pick u_pick (
        .i_req_i    (i_req),
        .d_req_i    (d_read | d_write),
`ifdef ARB_ROUND_ROBIN_EN
        .last_gnt_i (hist_q),
`endif
        .valid_o    (pick_valid_s),
        .gnt_o      (pick_gnt_s)
    );

    // Next-state logic: grant in IDLE, hold the bus until waitrequest drops,
    // then pulse done for one RESP cycle.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        read_d    = read_q;
        write_d   = write_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        hist_d    = hist_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    gnt_d   = pick_gnt_s;
                    state_d = BUS;
`ifdef ARB_ROUND_ROBIN_EN
                    hist_d  = pick_gnt_s;
`endif
                    if (pick_gnt_s == GNT_D) begin
                        addr_d  = d_address;
                        be_d    = d_byteenable;
                        wdata_d = d_writedata;
                        // A simultaneous read+write is resolved as a write.
                        if (d_write) begin
                            write_d = 1'b1;
                            read_d  = 1'b0;
                        end else begin
                            write_d = 1'b0;
                            read_d  = 1'b1;
                        end
                    end else begin
                        addr_d  = i_address;
                        be_d    = FETCH_BE;
                        wdata_d = 32'h0000_0000;
                        write_d = 1'b0;
                        read_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                if (!avm.avm_waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = RESP;
                    if (gnt_q == GNT_D) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = write_q ? 32'h0000_0000 : avm.avm_readdata;
                    end else begin
                        i_done_d  = 1'b1;
                        i_rdata_d = avm.avm_readdata;
                    end
                end else begin
                    state_d = BUS;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_I;
            addr_q    <= 32'h0000_0000;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0000_0000;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= 32'h0000_0000;
            d_rdata_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Grant history: remembers the last winner; resets to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= GNT_I;
        end else begin
            hist_q <= hist_d;
        end
    end
`endif

    assign avm.avm_address    = addr_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_read       = read_q;
    assign avm.avm_write      = write_q;
    assign i_done             = i_done_q;
    assign d_done             = d_done_q;
    assign i_rdata            = i_rdata_q;
    assign d_rdata            = d_rdata_q;

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// tb_avl_bus_arbiter: directed self-checking bench for avl_bus_arbiter with a
// behavioural Avalon memory slave (waitrequest high 2 cycles, low on the 3rd).
module tb_avl_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_address;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [3:0]  d_byteenable;
    logic [31:0] d_writedata;
    logic        d_done;
    logic [31:0] d_rdata;

    int n_pass;
    int n_fail;
    int n_total;

    avl_bus_arbiter_if bus_if ();

    avl_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_address    (i_address),
        .i_done       (i_done),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_byteenable (d_byteenable),
        .d_writedata  (d_writedata),
        .d_done       (d_done),
        .d_rdata      (d_rdata),
        .avm          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave model
    logic [31:0] mem [0:255];
    logic [1:0]  wait_cnt;

    always @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 2'd0;
        end else if (bus_if.avm_read || bus_if.avm_write) begin
            if (wait_cnt != 2'd3) wait_cnt <= wait_cnt + 2'd1;
        end else begin
            wait_cnt <= 2'd0;
        end
    end

    always_comb begin
        bus_if.avm_waitrequest = (bus_if.avm_read || bus_if.avm_write) ? (wait_cnt < 2'd2) : 1'b1;
        bus_if.avm_readdata    = mem[bus_if.avm_address[9:2]];
    end

    always @(posedge clk) begin
        if (!rst && bus_if.avm_write && !bus_if.avm_waitrequest) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_if.avm_byteenable[b])
                    mem[bus_if.avm_address[9:2]][b*8 +: 8] <= bus_if.avm_writedata[b*8 +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        for (int k = 0; k < 256; k++) mem[k] = 32'h0000_0000;
        mem[0] = 32'h2402_0005;               // word at 0xBFC00000
        rst = 1'b1; i_req = 1'b0; i_address = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_address = 32'h0;
        d_byteenable = 4'b0000; d_writedata = 32'h0;
        tick(); tick();

        // Reset state
        chk("rst_avm_read",  {31'd0, bus_if.avm_read}, 32'd0);
        chk("rst_avm_write", {31'd0, bus_if.avm_write}, 32'd0);
        chk("rst_avm_addr",  bus_if.avm_address, 32'h0);
        chk("rst_avm_be",    {28'd0, bus_if.avm_byteenable}, 32'd0);
        chk("rst_dones",     {30'd0, i_done, d_done}, 32'd0);
        chk("rst_rdata",     i_rdata | d_rdata, 32'h0);
        rst = 1'b0;

        // Fetch only
        i_req = 1'b1; i_address = 32'hBFC0_0000;
        tick();
        chk("f_read_n1", {31'd0, bus_if.avm_read}, 32'd1);
        chk("f_be_n1",   {28'd0, bus_if.avm_byteenable}, 32'hF);
        chk("f_addr_n1", bus_if.avm_address, 32'hBFC0_0000);
        tick();
        chk("f_nodone_n2", {30'd0, i_done, d_done}, 32'd0);
        chk("f_read_n2", {31'd0, bus_if.avm_read}, 32'd1);
        tick();
        chk("f_nodone_n3", {30'd0, i_done, d_done}, 32'd0);
        tick();
        chk("f_idone_n4", {31'd0, i_done}, 32'd1);
        chk("f_irdata",   i_rdata, 32'h2402_0005);
        chk("f_ddone",    {31'd0, d_done}, 32'd0);
        chk("f_read_off", {31'd0, bus_if.avm_read}, 32'd0);
        i_req = 1'b0;
        tick();
        chk("f_idone_n5", {31'd0, i_done}, 32'd0);
        chk("f_irdata_hold", i_rdata, 32'h2402_0005);

        // Store then load
        d_write = 1'b1; d_address = 32'h0000_0100; d_byteenable = 4'b0011;
        d_writedata = 32'hAABB_CCDD;
        tick();
        chk("st_write", {30'd0, bus_if.avm_read, bus_if.avm_write}, 32'd1);
        chk("st_be",    {28'd0, bus_if.avm_byteenable}, 32'h3);
        chk("st_wdata", bus_if.avm_writedata, 32'hAABB_CCDD);
        tick(); tick(); tick();
        chk("st_ddone", {31'd0, d_done}, 32'd1);
        chk("st_rdata", d_rdata, 32'h0);
        d_write = 1'b0;
        tick();
        d_read = 1'b1; d_byteenable = 4'b1111;
        tick();
        chk("ld_read", {30'd0, bus_if.avm_read, bus_if.avm_write}, 32'd2);
        tick(); tick(); tick();
        chk("ld_ddone", {31'd0, d_done}, 32'd1);
        chk("ld_rdata", d_rdata, 32'h0000_CCDD);
        d_read = 1'b0;
        tick();
        chk("ld_ddone_off", {31'd0, d_done}, 32'd0);

`ifdef ARB_ROUND_ROBIN_EN
        // Simultaneous requests held for 4 transactions: D, I, D, I
        rst = 1'b1; tick(); rst = 1'b0;
        i_req = 1'b1; i_address = 32'hBFC0_0000;
        d_read = 1'b1; d_address = 32'h0000_0100;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("rr_addr", bus_if.avm_address, (t % 2 == 0) ? 32'h0000_0100 : 32'hBFC0_0000);
            tick(); tick(); tick();
            chk("rr_done", {30'd0, i_done, d_done}, (t % 2 == 0) ? 32'd1 : 32'd2);
            if (t == 3) begin
                i_req = 1'b0; d_read = 1'b0;
            end
            tick();
        end
`else
        // Simultaneous requests: data first, then fetch
        i_req = 1'b1; i_address = 32'hBFC0_0000;
        d_read = 1'b1; d_address = 32'h0000_0100;
        tick();
        chk("sim_d_addr", bus_if.avm_address, 32'h0000_0100);
        tick(); tick(); tick();
        chk("sim_d_done", {30'd0, i_done, d_done}, 32'd1);
        chk("sim_d_rdata", d_rdata, 32'h0000_CCDD);
        d_read = 1'b0;
        tick();
        tick();
        chk("sim_i_addr", bus_if.avm_address, 32'hBFC0_0000);
        chk("sim_i_be",   {28'd0, bus_if.avm_byteenable}, 32'hF);
        tick(); tick(); tick();
        chk("sim_i_done", {30'd0, i_done, d_done}, 32'd2);
        chk("sim_i_rdata", i_rdata, 32'h2402_0005);
        i_req = 1'b0;
        tick();
`endif

        // Protocol violation: read and write together -> write only
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0104;
        d_byteenable = 4'b1111; d_writedata = 32'h1234_5678;
        tick();
        chk("pv_wr_only", {30'd0, bus_if.avm_read, bus_if.avm_write}, 32'd1);
        tick(); tick(); tick();
        chk("pv_ddone", {31'd0, d_done}, 32'd1);
        chk("pv_rdata", d_rdata, 32'h0);
        d_read = 1'b0; d_write = 1'b0;
        tick();
        chk("pv_ddone_once", {31'd0, d_done}, 32'd0);
        chk("pv_mem", mem[65], 32'h1234_5678);

        // Reset mid-transaction
        i_req = 1'b1; i_address = 32'hBFC0_0000;
        tick();
        chk("rm_read", {31'd0, bus_if.avm_read}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rm_clr_rw", {30'd0, bus_if.avm_read, bus_if.avm_write}, 32'd0);
        chk("rm_clr_addr", bus_if.avm_address, 32'h0);
        chk("rm_clr_done", {30'd0, i_done, d_done}, 32'd0);
        chk("rm_clr_rdata", i_rdata | d_rdata, 32'h0);
        rst = 1'b0;
        tick();
        chk("rm2_read", {31'd0, bus_if.avm_read}, 32'd1);
        chk("rm2_nodone", {31'd0, i_done}, 32'd0);
        tick(); tick();
        chk("rm2_nodone3", {31'd0, i_done}, 32'd0);
        tick();
        chk("rm2_idone", {31'd0, i_done}, 32'd1);
        chk("rm2_irdata", i_rdata, 32'h2402_0005);
        i_req = 1'b0;
        tick();
        chk("rm2_idone_off", {31'd0, i_done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
